// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two-requester arbiter in front of a single 32-bit left shifter. A granted
//   request is shifted combinationally and the result is registered into
//   rsp_data, where it stays until its owner consumes it. A new request may be
//   accepted in the same cycle the held result is consumed, so back-to-back
//   traffic sustains one operation per cycle.
//
// Parameters
//   RR_EN        1 = round-robin between contending requesters,
//                0 = fixed priority, requester 0 highest
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low (0 = in reset)
//   reqN_valid   requester N has a shift operation pending
//   reqN_data    operand to shift left
//   reqN_amt     left-shift amount 0..31
//   reqN_ready   request N accepted this cycle (with reqN_valid)
//   rspN_valid   result held for requester N
//   rspN_ready   requester N consumes its result
//   rsp_data     registered shift result shared by both requesters
//   busy         a result is currently held
module shift_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_data,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req0_amt,
    input  logic [4:0]  req1_amt,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner;
    logic        last_grant;
    logic        consume;
    logic        can_accept;
    logic        grant;
    logic        accept;
    logic [31:0] sel_data;
    logic [4:0]  sel_amt;
    logic [31:0] shifted;

    // Arbitration and next-state. The reset term keeps both ready outputs low
    // while reset is held, since IDLE alone would otherwise grant.
    always_comb begin
        consume    = 1'b0;
        can_accept = 1'b0;
        grant      = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_next = state;

        consume    = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
        can_accept = reset && ((state == IDLE) || consume);

        // A lone requester always wins; contention uses the configured policy.
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? ~last_grant : 1'b0;
        end else begin
            grant = req1_valid;
        end

        accept     = can_accept && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;

        if (accept) begin
            state_next = RESP;
        end else if (consume) begin
            state_next = IDLE;
        end
    end

    // Single shared shifter fed by the granted requester's operands.
    always_comb begin
        sel_data = grant ? req1_data : req0_data;
        sel_amt  = grant ? req1_amt  : req0_amt;
        shifted  = sel_data << sel_amt;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result, owner and round-robin history. last_grant resets to 1 so the
    // first contested grant goes to requester 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_data   <= 32'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_data   <= shifted;
            owner      <= grant;
            last_grant <= grant;
        end
    end

    always_comb begin
        busy       = (state == RESP);
        rsp0_valid = busy && !owner;
        rsp1_valid = busy && owner;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
//   Drives a round-robin instance (index 0) and a fixed-priority instance
//   (index 1) with independent random traffic. A reference model predicts
//   every grant and queues the expected result; a monitor pops and compares
//   whenever an instance hands a result to its requester.
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid  [2][2];
    logic [31:0] in_data   [2][2];
    logic [4:0]  in_amt    [2][2];
    logic        in_ready  [2][2];
    logic        out_valid [2][2];
    logic        out_ready [2][2];
    logic [31:0] out_data  [2];
    logic        out_busy  [2];

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];
    exp_t mon_e;
    int   mon_sz;
    logic mon_who;

    bit   holding  [2];
    bit   owner    [2];
    bit   last     [2];
    bit   accepted [2][2];
    bit   checking = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    shift_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (in_valid[0][0]),
        .req1_valid (in_valid[0][1]),
        .req0_data  (in_data[0][0]),
        .req1_data  (in_data[0][1]),
        .req0_amt   (in_amt[0][0]),
        .req1_amt   (in_amt[0][1]),
        .req0_ready (in_ready[0][0]),
        .req1_ready (in_ready[0][1]),
        .rsp0_valid (out_valid[0][0]),
        .rsp1_valid (out_valid[0][1]),
        .rsp0_ready (out_ready[0][0]),
        .rsp1_ready (out_ready[0][1]),
        .rsp_data   (out_data[0]),
        .busy       (out_busy[0])
    );

    shift_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (in_valid[1][0]),
        .req1_valid (in_valid[1][1]),
        .req0_data  (in_data[1][0]),
        .req1_data  (in_data[1][1]),
        .req0_amt   (in_amt[1][0]),
        .req1_amt   (in_amt[1][1]),
        .req0_ready (in_ready[1][0]),
        .req1_ready (in_ready[1][1]),
        .rsp0_valid (out_valid[1][0]),
        .rsp1_valid (out_valid[1][1]),
        .rsp0_ready (out_ready[1][0]),
        .rsp1_ready (out_ready[1][1]),
        .rsp_data   (out_data[1]),
        .busy       (out_busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Left shift as multiplication by a power of two, truncated to 32 bits.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a);
        logic [63:0] prod;
        prod = {32'd0, d} * (64'd1 << a);
        return prod[31:0];
    endfunction

    // Winner among valid requesters; -1 when nobody asks.
    function automatic int pick_grant(input int i, input logic v0, input logic v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1)  return 0;
        if (!v0 && v1)  return 1;
        if (i == 1)     return 0;
        return last[i] ? 0 : 1;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0001;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_amt();
        case ($urandom_range(0, 5))
            0:       return 5'd0;
            1:       return 5'd31;
            2:       return 5'd16;
            3:       return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) q_rr.push_back(e);
        else        q_fp.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            holding[i] = 1'b0;
            owner[i]   = 1'b0;
            last[i]    = 1'b1;
            for (int r = 0; r < 2; r++) accepted[i][r] = 1'b0;
        end
        q_rr.delete();
        q_fp.delete();
    endtask

    // New operations appear with probability p_req (held until accepted);
    // each consumer is ready with probability p_rsp.
    task automatic apply_stimulus(input int p_req, input int p_rsp);
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (accepted[i][r]) begin
                    in_valid[i][r] = 1'b0;
                    accepted[i][r] = 1'b0;
                end
                if (!in_valid[i][r] && ($urandom_range(0, 99) < p_req)) begin
                    in_valid[i][r] = 1'b1;
                    in_data[i][r]  = rand_data();
                    in_amt[i][r]   = rand_amt();
                end
                out_ready[i][r] = ($urandom_range(0, 99) < p_rsp);
            end
        end
    endtask

    // Predict this cycle's grant from the arbitration rules and compare the
    // ready outputs; queue the expected result of any accepted operation.
    task automatic check_output();
        int  g;
        bit  consumed;
        bit  can;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy[%0d]", i), 32'(out_busy[i]), 32'(holding[i]));
            consumed = holding[i] && out_ready[i][owner[i]];
            can      = !holding[i] || consumed;
            g        = can ? pick_grant(i, in_valid[i][0], in_valid[i][1]) : -1;
            check($sformatf("req0_ready[%0d]", i), 32'(in_ready[i][0]), 32'(g == 0));
            check($sformatf("req1_ready[%0d]", i), 32'(in_ready[i][1]), 32'(g == 1));
            if (g >= 0) begin
                push_exp(i, '{who: 1'(g), data: ref_shift(in_data[i][g], in_amt[i][g])});
                accepted[i][g] = 1'b1;
                holding[i]     = 1'b1;
                owner[i]       = 1'(g);
                last[i]        = 1'(g);
            end else if (consumed) begin
                holding[i] = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(input int n, input int p_req, input int p_rsp);
        repeat (n) begin
            @(negedge clock);
            check_output();
            @(posedge clock);
            #1;
            apply_stimulus(p_req, p_rsp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s rsp0_valid[%0d]", tag, i), 32'(out_valid[i][0]), 32'd0);
            check($sformatf("%s rsp1_valid[%0d]", tag, i), 32'(out_valid[i][1]), 32'd0);
            check($sformatf("%s busy[%0d]", tag, i), 32'(out_busy[i]), 32'd0);
            check($sformatf("%s rsp_data[%0d]", tag, i), out_data[i], 32'd0);
            check($sformatf("%s req0_ready[%0d]", tag, i), 32'(in_ready[i][0]), 32'd0);
            check($sformatf("%s req1_ready[%0d]", tag, i), 32'(in_ready[i][1]), 32'd0);
        end
    endtask

    // Scoreboard monitor: whenever a result is presented it must match the
    // oldest outstanding expectation; it retires when the owner consumes it.
    always @(negedge clock) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                if (out_valid[i][0] || out_valid[i][1]) begin
                    check($sformatf("rsp_onehot[%0d]", i),
                          32'(out_valid[i][0] && out_valid[i][1]), 32'd0);
                    mon_sz  = (i == 0) ? q_rr.size() : q_fp.size();
                    mon_who = out_valid[i][1];
                    check($sformatf("rsp_expected[%0d]", i), 32'(mon_sz != 0), 32'd1);
                    if (mon_sz != 0) begin
                        mon_e = (i == 0) ? q_rr[0] : q_fp[0];
                        check($sformatf("rsp_owner[%0d]", i), 32'(mon_who), 32'(mon_e.who));
                        check($sformatf("rsp_data[%0d]", i), out_data[i], mon_e.data);
                        if (out_ready[i][mon_who]) begin
                            if (i == 0) void'(q_rr.pop_front());
                            else        void'(q_fp.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                in_valid[i][r]  = 1'b0;
                in_data[i][r]   = 32'd0;
                in_amt[i][r]    = 5'd0;
                out_ready[i][r] = 1'b1;
            end
        end
        // First operations wait during reset: a lone 1<<31 on the round-robin
        // instance and a contested pair on the fixed-priority instance.
        in_valid[0][0] = 1'b1; in_data[0][0] = 32'h0000_0001; in_amt[0][0] = 5'd31;
        in_valid[1][0] = 1'b1; in_data[1][0] = 32'hFFFF_FFFF; in_amt[1][0] = 5'd5;
        in_valid[1][1] = 1'b1; in_data[1][1] = 32'hFFFF_FFFF; in_amt[1][1] = 5'd16;

        repeat (2) @(posedge clock);
        #2;
        check_reset_state("reset");
        reset    = 1'b1;
        checking = 1'b1;

        $display("[TB] contention, all consumers ready");
        run_cycles(40, 100, 100);
        $display("[TB] random traffic");
        run_cycles(150, 50, 50);
        $display("[TB] heavy backpressure");
        run_cycles(150, 70, 20);

        // Reset while the round-robin instance holds a result.
        guard = 0;
        while (!holding[0] && guard < 200) begin
            run_cycles(1, 60, 30);
            guard++;
        end
        check("reset_setup_holding", 32'(holding[0]), 32'd1);
        checking = 1'b0;
        reset    = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(posedge clock);
        #2;
        check_reset_state("mid_reset_held");
        model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                in_valid[i][r] = 1'b1;
                in_data[i][r]  = rand_data();
                in_amt[i][r]   = rand_amt();
            end
        end
        reset    = 1'b1;
        checking = 1'b1;

        $display("[TB] traffic after reset");
        run_cycles(100, 60, 60);
        run_cycles(8, 0, 100);
        check("rr_queue_drained", q_rr.size(), 32'd0);
        check("fp_queue_drained", q_fp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has a shift operation pending.
REQ-005 SHALL have ports req0_data / req1_data  input  32 each  operand to shift left.
REQ-006 SHALL have ports req0_amt / req1_amt  input  5 each  left-shift amount, 0..31.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle when ready and valid are both 1.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1 each  result held for that requester.
REQ-009 SHALL have ports rsp0_ready / rsp1_ready  input  1 each  requester consumes its result.
REQ-010 SHALL have port rsp_data  output  32  registered shift result, shared by both requesters.
REQ-011 SHALL have port busy  output  1  high while a result is held (state RESP).

Function
REQ-012 SHALL contain one combinational 32-bit logical left shifter, zero-fill, result = data << amt, truncated to 32 bits; amt = 0 passes data unchanged.
REQ-013 SHALL implement a two-state FSM: IDLE (no result held) and RESP (result held for owner, owner register 0 or 1).
REQ-014 In IDLE, SHALL assert reqN_ready only for the requester granted this cycle; at most one reqN_ready high per cycle.
REQ-015 Grant with one valid requester SHALL go to that requester regardless of RR_EN.
REQ-016 Grant with both valid and RR_EN=1 SHALL go to the requester that did not receive the most recent grant; last-grant register resets to 1, so first contested grant goes to 0.
REQ-017 Grant with both valid and RR_EN=0 SHALL go to requester 0.
REQ-018 On acceptance, SHALL register the shift result into rsp_data, set owner, update last-grant, and enter RESP next cycle; latency from acceptance to rspN_valid = 1 cycle.
REQ-019 In RESP, SHALL assert only rsp<owner>_valid and hold rsp_data stable until rsp<owner>_ready = 1.
REQ-020 SHALL ignore rspN_ready of the non-owner and whenever rspN_valid is 0.
REQ-021 In RESP, when rsp<owner>_ready = 1 and at least one request is valid, SHALL apply the grant rules of REQ-015..017 in that same cycle, giving back-to-back throughput of one operation per cycle.
REQ-022 In RESP, when rsp<owner>_ready = 1 and no request is valid, SHALL return to IDLE next cycle.
REQ-023 In RESP without consumption, SHALL hold all reqN_ready at 0.
REQ-024 reqN_ready SHALL be a combinational function of state, owner, last-grant, reqN_valid and rsp<owner>_ready only; it SHALL NOT depend on data or amt.
REQ-025 Requesters SHALL hold valid, data and amt stable until accepted; the arbiter SHALL NOT be required to tolerate withdrawal.

Reset
REQ-026 While reset = 0, SHALL force IDLE, owner = 0, last-grant = 1, rsp_data = 0, all rspN_valid = 0, busy = 0, all reqN_ready = 0.
REQ-027 Reset asserted in RESP SHALL discard the held result, with no rspN_valid pulse after release.
REQ-028 First grant SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-029 Single op: req0 data=0x0000_0001, amt=31 -> ready0 same cycle; next cycle rsp0_valid=1, rsp_data=0x8000_0000.
REQ-030 Edge amounts: data=0xFFFF_FFFF with amt=0 -> rsp_data 0xFFFF_FFFF; with amt=16 -> 0xFFFF_0000; with amt=5 -> 0xFFFF_FFE0.
REQ-031 Contention, RR_EN=1: both valid continuously, rspN_ready tied 1 -> grants alternate 0,1,0,1; one result per cycle after the first.
REQ-032 Contention, RR_EN=0: both valid, rsp0_ready=1 -> requester 0 granted every cycle; req1_ready stays 0 until req0_valid drops.
REQ-033 Backpressure: rsp1_ready held 0 for 5 cycles with req0 pending -> rsp_data stable, req0_ready=0, rsp0_valid=0 throughout; req0 granted in the cycle rsp1_ready rises.
REQ-034 Reset mid-RESP: reset low for one cycle while rsp0_valid=1 -> rsp0_valid=0, busy=0, rsp_data=0 immediately (asynchronous); next contested grant goes to requester 0.
